// File: rtl/metadata_pack_pkg.sv
// Shared definitions for the metadata packer / unpacker pair.
//
// Purpose: derive the per-sample chunk width and the number of chunks needed
// to carry one metadata word, so both ends of the link agree by construction.
// Contents:
//   default_* widths    : nominal sample / metadata geometry
//   pack_width(dw, dwu) : spare high-order bits per sample (chunk width)
//   n_chunks(mw, pw)    : chunks per metadata frame, rounded up
package metadata_pack_pkg;

  localparam int default_data_width      = 16;
  localparam int default_data_width_used = 12;
  localparam int default_meta_data_width = 465;

  function automatic int pack_width(input int dw, input int dwu);
    return dw - dwu;
  endfunction

  function automatic int n_chunks(input int mw, input int pw);
    return (mw + pw - 1) / pw;
  endfunction

endpackage

// File: rtl/unpack_metadata.sv
// unpack_metadata: receive-side counterpart of the metadata packer.
//
// Each incoming sample is {chunk, sample}. The low data_width_used bits are
// re-emitted as a clean sample (zero- or sign-extended); the high chunk bits
// of successive samples after an init are collected, LSB chunk first, into
// the full metadata word.
//
// Ports:
//   clock      : system clock
//   reset      : synchronous, active-high reset
//   enable     : block enable; strobe_in ignored while low
//   init       : start of a new metadata frame (wins over strobe_in)
//   data_in    : packed sample {chunk, sample}
//   strobe_in  : data_in valid
//   data_out   : extracted sample, registered
//   strobe_out : data_out valid, one clock after the accepted strobe
//   meta_data  : last completely reassembled metadata word
//   meta_valid : one-cycle pulse, aligned with strobe_out, when meta_data updates
//   meta_abort : one-cycle pulse when init truncates a partly collected frame
module unpack_metadata
  import metadata_pack_pkg::*;
#(
  parameter int data_width      = default_data_width,
  parameter int data_width_used = default_data_width_used,
  parameter int meta_data_width = default_meta_data_width,
  parameter bit sign_extend     = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       init,
  input  logic [data_width-1:0]      data_in,
  input  logic                       strobe_in,
  output logic [data_width-1:0]      data_out,
  output logic                       strobe_out,
  output logic [meta_data_width-1:0] meta_data,
  output logic                       meta_valid,
  output logic                       meta_abort
);

  localparam int pw    = pack_width(data_width, data_width_used);
  localparam int nch   = n_chunks(meta_data_width, pw);
  localparam int cnt_w = $clog2(nch + 1);
  localparam int asm_w = nch * pw;

  localparam logic [cnt_w-1:0] nch_c  = cnt_w'(nch);
  localparam logic [cnt_w-1:0] last_c = cnt_w'(nch - 1);

  logic [cnt_w-1:0]      cnt;
  logic [asm_w-1:0]      asm_buf;
  logic                  collecting;

  logic [asm_w-1:0]      asm_next;
  logic [data_width-1:0] sample_ext;
  logic                  accept;

  assign accept = enable & strobe_in;

  // Buffer image with the current chunk dropped into its slot; it feeds both
  // the buffer register and, on the last chunk, meta_data, so the final
  // chunk reaches meta_data in the same cycle it arrives.
  // NOTE: every variable is given a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    asm_next = asm_buf;
    if (cnt < nch_c)
      asm_next[int'(cnt)*pw +: pw] = data_in[data_width-1:data_width_used];

    sample_ext = '0;
    sample_ext[data_width_used-1:0] = data_in[data_width_used-1:0];
    if (sign_extend)
      sample_ext[data_width-1:data_width_used] = {pw{data_in[data_width_used-1]}};
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the assembly buffer is cleared on reset even though it is
      // wide, so a frame never inherits stale chunks across a reset.
      asm_buf    <= '0;
      cnt        <= '0;
      collecting <= 1'b0;
      data_out   <= '0;
      strobe_out <= 1'b0;
      meta_data  <= '0;
      meta_valid <= 1'b0;
      meta_abort <= 1'b0;
    end else if (init) begin
      // A frame is only "truncated" if it had started but not completed.
      meta_abort <= collecting && (cnt != '0) && (cnt < nch_c);
      cnt        <= '0;
      collecting <= 1'b1;
      strobe_out <= 1'b0;
      meta_valid <= 1'b0;
    end else if (accept) begin
      data_out   <= sample_ext;
      strobe_out <= 1'b1;
      meta_valid <= 1'b0;
      meta_abort <= 1'b0;
      if (collecting && (cnt < nch_c)) begin
        asm_buf <= asm_next;
        cnt     <= cnt + 1'b1;
        if (cnt == last_c) begin
          // Pad bits above meta_data_width in the top chunk are dropped.
          meta_data  <= asm_next[meta_data_width-1:0];
          meta_valid <= 1'b1;
          collecting <= 1'b0;
        end
      end
    end else begin
      strobe_out <= 1'b0;
      meta_valid <= 1'b0;
      meta_abort <= 1'b0;
    end
  end

endmodule
